// File: rtl/pc_pkg.sv
// Shared CPU definitions: control-unit operation codes and PC arithmetic constants.
package pc_pkg;

  typedef enum logic [5:0] {
    CU_LUI, CU_AUIPC, CU_JAL, CU_JALR,
    CU_BEQ, CU_BNE, CU_BLT, CU_BGE, CU_BLTU, CU_BGEU,
    CU_LB, CU_LH, CU_LW, CU_LBU, CU_LHU,
    CU_SB, CU_SH, CU_SW,
    CU_ADDI, CU_SLTI, CU_SLTIU, CU_XORI, CU_ORI, CU_ANDI, CU_SLLI, CU_SRLI, CU_SRAI,
    CU_ADD, CU_SUB, CU_SLL, CU_SLT, CU_SLTU, CU_XOR, CU_SRL, CU_SRA, CU_OR, CU_AND,
    CU_ERROR
  } cuOPType;

  localparam logic [31:0] PC_STEP   = 32'd4;
  localparam logic [31:0] JALR_MASK = 32'hFFFF_FFFE;

endpackage

// File: rtl/pc_next.sv
// Combinational next-PC selection: sequential, jump target or branch decision.
module pc_next
  import pc_pkg::*;
(
  input  logic [31:0] pc_cur,
  input  logic [5:0]  cuOP,
  input  logic [31:0] rs1Read,
  input  logic [31:0] signExtend,
  input  logic        ALUneg,
  input  logic        Zero,
  output logic [31:0] next_pc
);

  logic [31:0] seq_pc;
  logic [31:0] rel_pc;
  logic [31:0] jalr_pc;
  logic        taken;

  assign seq_pc  = pc_cur + PC_STEP;
  assign rel_pc  = pc_cur + signExtend;
  assign jalr_pc = (rs1Read + signExtend) & JALR_MASK;

  always_comb begin
    taken   = 1'b0;
    next_pc = seq_pc;
    case (cuOP)
      CU_JAL:  next_pc = rel_pc;
      CU_JALR: next_pc = jalr_pc;
      CU_BEQ, CU_BNE, CU_BLT, CU_BLTU, CU_BGE, CU_BGEU: begin
        // BLT/BLTU share one flag: the ALU already chose signed vs unsigned
        case (cuOP)
          CU_BEQ:          taken = Zero;
          CU_BNE:          taken = ~Zero;
          CU_BLT, CU_BLTU: taken = ALUneg;
          default:         taken = Zero | ~ALUneg;
        endcase
        next_pc = taken ? rel_pc : seq_pc;
      end
      default: next_pc = seq_pc;
    endcase
  end

endmodule

// File: rtl/pc.sv
// Program-counter register: reset to RESET_ADDR, advance on iready, else hold.
module pc
  import pc_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        nRST,
  input  logic [5:0]  cuOP,
  input  logic [31:0] rs1Read,
  input  logic [31:0] signExtend,
  input  logic        ALUneg,
  input  logic        Zero,
  input  logic        iready,
  output logic [31:0] PCaddr
);

  logic [31:0] pc_reg;
  logic [31:0] pc_next_val;

  pc_next u_pc_next (
    .pc_cur     (pc_reg),
    .cuOP       (cuOP),
    .rs1Read    (rs1Read),
    .signExtend (signExtend),
    .ALUneg     (ALUneg),
    .Zero       (Zero),
    .next_pc    (pc_next_val)
  );

  // nRST is active-high despite its name; it dominates iready
  always_ff @(posedge clk) begin
    if (nRST)
      pc_reg <= RESET_ADDR;
    else if (iready)
      pc_reg <= pc_next_val;
  end

  assign PCaddr = pc_reg;

endmodule

// File: tb/tb_pc.sv
// Self-checking bench for pc: directed cases plus random ops against a behavioural model.
module tb_pc;
  import pc_pkg::*;

  logic        tb_clk = 1'b0;
  logic        nRST = 1'b1;
  logic [5:0]  cuOP = 6'(CU_ADDI);
  logic [31:0] rs1Read = '0;
  logic [31:0] signExtend = '0;
  logic        ALUneg = 1'b0;
  logic        Zero = 1'b0;
  logic        iready = 1'b0;
  logic [31:0] PCaddr;

  int          chk_cnt = 0;
  int          pass_cnt = 0;
  logic        chk_en = 1'b0;
  logic [31:0] model_pc = '0;

  pc #(.RESET_ADDR(32'h0000_0000)) dut (
    .clk        (tb_clk),
    .nRST       (nRST),
    .cuOP       (cuOP),
    .rs1Read    (rs1Read),
    .signExtend (signExtend),
    .ALUneg     (ALUneg),
    .Zero       (Zero),
    .iready     (iready),
    .PCaddr     (PCaddr)
  );

  always #5 tb_clk = ~tb_clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    chk_cnt++;
    if (got === want) pass_cnt++;
    else $display("FAIL %s: PCaddr=%h expected=%h", name, got, want);
  endtask

  // Architectural next address from the instruction's meaning
  function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [5:0] op,
                                             input logic [31:0] rs1, input logic [31:0] imm,
                                             input logic neg, input logic z);
    logic [31:0] seq, tgt, jr;
    seq = cur + 32'd4;
    tgt = cur + imm;
    jr  = rs1 + imm;
    jr  = jr & ~32'd1;
    if (op == 6'(CU_JAL))  return tgt;
    if (op == 6'(CU_JALR)) return jr;
    if (op == 6'(CU_BEQ))  return z ? tgt : seq;
    if (op == 6'(CU_BNE))  return z ? seq : tgt;
    if (op == 6'(CU_BLT) || op == 6'(CU_BLTU)) return neg ? tgt : seq;
    if (op == 6'(CU_BGE) || op == 6'(CU_BGEU)) return (z || !neg) ? tgt : seq;
    return seq;
  endfunction

  // Drive one cycle of inputs at the falling edge and advance the model after the rising edge
  task automatic step(input logic [5:0] op, input logic [31:0] rs1, input logic [31:0] imm,
                      input logic neg, input logic z, input logic rdy, input logic rst);
    logic [31:0] expv;
    @(negedge tb_clk);
    cuOP = op; rs1Read = rs1; signExtend = imm; ALUneg = neg; Zero = z;
    iready = rdy; nRST = rst;
    if (rst)      expv = 32'h0;
    else if (rdy) expv = model_next(model_pc, op, rs1, imm, neg, z);
    else          expv = model_pc;
    @(posedge tb_clk);
    #1;
    model_pc = expv;
    $display("step op=%0d rst=%0b rdy=%0b rs1=%h imm=%h neg=%0b z=%0b -> pc=%h",
             op, rst, rdy, rs1, imm, neg, z, PCaddr);
  endtask

  task automatic goto_pc(input logic [31:0] addr);
    step(6'(CU_JALR), addr, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  always @(negedge tb_clk) begin
    if (chk_en) check("pc_cycle", PCaddr, model_pc);
  end

  cuOPType     br_op  [16] = '{CU_BEQ, CU_BEQ, CU_BNE, CU_BNE, CU_BLT, CU_BLT, CU_BLTU, CU_BLTU,
                               CU_BGE, CU_BGE, CU_BGE, CU_BGEU, CU_BGEU, CU_BGEU, CU_BEQ, CU_BNE};
  logic        br_neg [16] = '{0, 0, 0, 0, 1, 0, 1, 0, 0, 1, 1, 0, 1, 1, 1, 1};
  logic        br_z   [16] = '{1, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 1, 0};
  logic [31:0] br_exp [16] = '{32'h60, 32'h44, 32'h60, 32'h44, 32'h60, 32'h44, 32'h60, 32'h44,
                               32'h60, 32'h60, 32'h44, 32'h60, 32'h60, 32'h44, 32'h60, 32'h60};

  initial begin
    // Reset and sequential advance
    step(6'(CU_ADDI), 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    step(6'(CU_ADDI), 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("reset", PCaddr, 32'h0);
    chk_en = 1'b1;
    step(6'(CU_ADDI), 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("seq_4", PCaddr, 32'h4);
    step(6'(CU_ADDI), 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("seq_8", PCaddr, 32'h8);

    // Hold with iready low, then reset
    for (int i = 0; i < 3; i++)
      step(6'(CU_JAL), 32'h1234, 32'h100, 1'b1, 1'b1, 1'b0, 1'b0);
    check("hold", PCaddr, 32'h8);
    step(6'(CU_ADDI), 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("reset_mid", PCaddr, 32'h0);

    // Jumps
    goto_pc(32'h100);
    step(6'(CU_JAL), 32'h0, 32'hFFFF_FFF0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("jal_neg", PCaddr, 32'hF0);
    step(6'(CU_JALR), 32'h2001, 32'h2, 1'b0, 1'b0, 1'b1, 1'b0);
    check("jalr_bit0", PCaddr, 32'h2002);

    // Branch decision table from PC=0x40, offset 0x20
    for (int i = 0; i < 16; i++) begin
      goto_pc(32'h40);
      step(6'(br_op[i]), 32'h0, 32'h20, br_neg[i], br_z[i], 1'b1, 1'b0);
      check($sformatf("branch_%0d", i), PCaddr, br_exp[i]);
    end

    // Wrap-around, error/undefined codes, reset beating iready
    goto_pc(32'hFFFF_FFFC);
    step(6'(CU_ADD), 32'h0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0);
    check("wrap", PCaddr, 32'h0);
    goto_pc(32'h10);
    step(6'(CU_ERROR), 32'h0, 32'h40, 1'b1, 1'b1, 1'b1, 1'b0);
    check("cu_error", PCaddr, 32'h14);
    step(6'd63, 32'h0, 32'h40, 1'b1, 1'b1, 1'b1, 1'b0);
    check("undef_op", PCaddr, 32'h18);
    step(6'(CU_JAL), 32'h0, 32'h40, 1'b0, 1'b0, 1'b1, 1'b1);
    check("rst_vs_rdy", PCaddr, 32'h0);

    // Random traffic: branch flags derived from real operand comparisons
    for (int n = 0; n < 400; n++) begin
      logic [5:0]  op;
      logic [31:0] a, b, rs1, imm;
      logic        neg, z;
      op  = 6'($urandom_range(0, 63));
      a   = $urandom;
      b   = ($urandom_range(0, 3) == 0) ? a : $urandom;
      rs1 = $urandom;
      imm = ($urandom_range(0, 1) == 0) ? $urandom : 32'($signed(12'($urandom)));
      z   = (a == b);
      if (op == 6'(CU_BLT) || op == 6'(CU_BGE)) neg = ($signed(a) < $signed(b));
      else if (op == 6'(CU_BLTU) || op == 6'(CU_BGEU)) neg = (a < b);
      else neg = 1'($urandom);
      step(op, rs1, imm, neg, z, ($urandom_range(0, 3) != 0), ($urandom_range(0, 40) == 0));
    end

    @(negedge tb_clk);
    #1;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
